// File: rtl/conv_window_addr_gen_if.sv
// conv_window_addr_gen_if: valid/ready beat stream carrying image address and weight index
//   master drives: out_valid, img_addr, w_idx, win_first, win_last, out_x, out_y
//   master receives: out_ready
//   slave is the mirror image (downstream consumer)
interface conv_window_addr_gen_if #(
    parameter int ADDR_W = 10,
    parameter int KIDX_W = 5,
    parameter int X_W    = 5,
    parameter int Y_W    = 5
);
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] img_addr;
    logic [KIDX_W-1:0] w_idx;
    logic              win_first;
    logic              win_last;
    logic [X_W-1:0]    out_x;
    logic [Y_W-1:0]    out_y;
    modport master(output out_valid, img_addr, w_idx, win_first, win_last, out_x, out_y, input out_ready);
    modport slave(input out_valid, img_addr, w_idx, win_first, win_last, out_x, out_y, output out_ready);
endinterface

// File: rtl/conv_window_addr_gen.sv
// conv_window_addr_gen: walks a KxK stride-1 window over an IMG_H x IMG_W map, one address/weight beat per accept
//   clk, rst   clock (rising edge), asynchronous active-high reset
//   start      one-cycle pulse, accepted only in IDLE
//   busy       high while a pass is running
//   done       one-cycle pulse after the final beat is accepted
//   bus        beat stream (master side): out_valid/out_ready, img_addr, w_idx, win_first, win_last, out_x, out_y
//   stall_cnt  (only with CONV_AG_STALL_CNT_EN) saturating count of RUN cycles with out_valid & !out_ready
module conv_window_addr_gen #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int K      = 5,
    parameter int ADDR_W = 10,
    parameter int KIDX_W = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done,
    conv_window_addr_gen_if.master bus
`ifdef CONV_AG_STALL_CNT_EN
    , output logic [15:0] stall_cnt
`endif
);
    localparam int OUT_W = IMG_W - K + 1;
    localparam int OUT_H = IMG_H - K + 1;
    localparam int KC_W  = K > 1 ? $clog2(K) : 1;
    localparam int X_W   = OUT_W > 1 ? $clog2(OUT_W) : 1;
    localparam int Y_W   = OUT_H > 1 ? $clog2(OUT_H) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t          state;
    logic [KC_W-1:0] kx, ky;
    logic [X_W-1:0]  ox;
    logic [Y_W-1:0]  oy;
    logic            valid_q;
    logic            kx_max, ky_max, ox_max, oy_max, fire;
    assign kx_max = kx == KC_W'(K - 1);
    assign ky_max = ky == KC_W'(K - 1);
    assign ox_max = ox == X_W'(OUT_W - 1);
    assign oy_max = oy == Y_W'(OUT_H - 1);
    assign fire   = valid_q & bus.out_ready;
    // every counter wraps to zero on the final beat, so the next pass starts clean
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            kx      <= '0;
            ky      <= '0;
            ox      <= '0;
            oy      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state   <= RUN;
                    busy    <= 1'b1;
                    valid_q <= 1'b1;
                end
                RUN: if (fire) begin
                    kx <= kx_max ? '0 : kx + 1'b1;
                    if (kx_max) ky <= ky_max ? '0 : ky + 1'b1;
                    if (kx_max && ky_max) ox <= ox_max ? '0 : ox + 1'b1;
                    if (kx_max && ky_max && ox_max) oy <= oy_max ? '0 : oy + 1'b1;
                    if (kx_max && ky_max && ox_max && oy_max) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        valid_q <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end
`ifdef CONV_AG_STALL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (state == IDLE && start)
            stall_cnt <= '0;
        else if (valid_q && !bus.out_ready && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif
    assign bus.out_valid = valid_q;
    assign bus.img_addr  = (ADDR_W'(oy) + ADDR_W'(ky)) * ADDR_W'(IMG_W) + ADDR_W'(ox) + ADDR_W'(kx);
    assign bus.w_idx     = KIDX_W'(ky) * KIDX_W'(K) + KIDX_W'(kx);
    assign bus.win_first = kx == '0 && ky == '0;
    assign bus.win_last  = kx_max && ky_max;
    assign bus.out_x     = ox;
    assign bus.out_y     = oy;
endmodule

// File: tb/tb_conv_window_addr_gen.sv
// tb_conv_window_addr_gen: directed and table-driven checks of the window address generator
module tb_conv_window_addr_gen;
    localparam int IW = 28, KK = 5, OW = 24, OH = 24;
    localparam int BEATS = OH * OW * KK * KK;
    typedef struct {
        int beat;
        int addr;
        int widx;
        bit f;
        bit l;
        int x;
        int y;
    } vec_t;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, busy, done;
`ifdef CONV_AG_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif
    int checks = 0, errors = 0;
    int beats, dones, stalls, seq_err, first_bad, stall_viol, cyc, first_cyc, done_cyc;
    bit prev_stall;
    logic [63:0] prev_out, cur;
    logic [63:0] cap[BEATS];
    vec_t vecs[9];

    conv_window_addr_gen_if #(.ADDR_W(10), .KIDX_W(5), .X_W(5), .Y_W(5)) bus();

    conv_window_addr_gen #(.IMG_W(28), .IMG_H(28), .K(5), .ADDR_W(10), .KIDX_W(5)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .busy(busy),
        .done(done),
        .bus(bus)
`ifdef CONV_AG_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] pk(input int a, input int w, input bit f, input bit l, input int x, input int y);
        return (64'(a) << 32) | (64'(w) << 24) | (64'(f) << 17) | (64'(l) << 16) | (64'(x) << 8) | 64'(y);
    endfunction

    function automatic logic [63:0] model(input int b);
        int kx, ky, ox, oy;
        kx = b % KK;
        ky = (b / KK) % KK;
        ox = (b / (KK * KK)) % OW;
        oy = b / (KK * KK * OW);
        return pk((oy + ky) * IW + ox + kx, ky * KK + kx, kx == 0 && ky == 0, kx == KK - 1 && ky == KK - 1, ox, oy);
    endfunction

    assign cur = pk(int'(bus.img_addr), int'(bus.w_idx), bus.win_first, bus.win_last, int'(bus.out_x), int'(bus.out_y));

    always @(negedge clk) begin
        cyc++;
        if (prev_stall && ({63'(0), bus.out_valid} != 64'd1 || cur != prev_out)) stall_viol++;
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_out = cur;
        if (bus.out_valid && !bus.out_ready) stalls++;
        if (bus.out_valid && bus.out_ready) begin
            if (beats == 0) first_cyc = cyc;
            if (beats < BEATS) cap[beats] = cur;
            if (cur != model(beats)) begin
                if (seq_err == 0) first_bad = beats;
                seq_err++;
            end
            beats++;
        end
        if (done) begin
            dones++;
            done_cyc = cyc;
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic clear_mon();
        beats = 0;
        dones = 0;
        stalls = 0;
        seq_err = 0;
        first_bad = -1;
        stall_viol = 0;
        prev_stall = 0;
    endtask

    task automatic run_pass(input bit rnd, input bit poke, input string tag);
        int n;
        clear_mon();
        @(posedge clk); #1;
        start = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_lat_valid"}, 64'(bus.out_valid), 64'd1);
        check({tag, "_lat_addr"}, 64'(bus.img_addr), 64'd0);
        check({tag, "_lat_first"}, 64'(bus.win_first), 64'd1);
        n = 0;
        while (!done && n < 40000) begin
            bus.out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            start = poke && (n == 100 || n == 7000);
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_timeout"}, 64'(n < 40000), 64'd1);
        if (poke) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check({tag, "_beats"}, 64'(beats), 64'(BEATS));
        check({tag, "_dones"}, 64'(dones), 64'd1);
        check({tag, "_seq_first_bad"}, 64'(seq_err == 0 ? -1 : first_bad), 64'(-1));
        check({tag, "_idle_after"}, {62'd0, busy, bus.out_valid}, 64'd0);
    endtask

    initial begin
        int n;
        vecs = '{
            '{0, 0, 0, 1, 0, 0, 0},
            '{5, 28, 5, 0, 0, 0, 0},
            '{7, 30, 7, 0, 0, 0, 0},
            '{24, 116, 24, 0, 1, 0, 0},
            '{25, 1, 0, 1, 0, 1, 0},
            '{49, 117, 24, 0, 1, 1, 0},
            '{599, 139, 24, 0, 1, 23, 0},
            '{600, 28, 0, 1, 0, 0, 1},
            '{14399, 783, 24, 0, 1, 23, 23}
        };
        clear_mon();
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_flags", {62'd0, bus.win_first, bus.win_last}, 64'd2);
        check("reset_xy", {48'd0, 3'd0, bus.out_x, 3'd0, bus.out_y}, 64'd0);
        check("reset_widx", 64'(bus.w_idx), 64'd0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("idle", {51'd0, busy, bus.out_valid, done, bus.img_addr}, 64'd0);
        end

        run_pass(1'b0, 1'b0, "full");
        check("full_done_latency", 64'(done_cyc - first_cyc), 64'(BEATS));
        for (int i = 0; i < 9; i++)
            check($sformatf("beat%0d", vecs[i].beat), cap[vecs[i].beat],
                  pk(vecs[i].addr, vecs[i].widx, vecs[i].f, vecs[i].l, vecs[i].x, vecs[i].y));

        run_pass(1'b1, 1'b1, "rnd");
        check("rnd_stable", 64'(stall_viol), 64'd0);
        check("rnd_stalled", 64'(stalls > 0), 64'd1);
`ifdef CONV_AG_STALL_CNT_EN
        check("rnd_stall_cnt", 64'(stall_cnt), 64'(stalls));
`endif

        clear_mon();
        @(posedge clk); #1;
        start = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (beats < 3000 && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        check("abort_reach", 64'(beats >= 3000), 64'd1);
        rst = 1'b1;
        #1;
        check("abort_rst", {51'd0, busy, bus.out_valid, done, bus.img_addr}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done", 64'(dones), 64'd0);
`ifdef CONV_AG_STALL_CNT_EN
        check("abort_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        run_pass(1'b0, 1'b0, "restart");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
